mux_nto1_stream: RTL
====================

Name: mux_nto1_stream

Overview:
- Parametrised N-to-1 streaming multiplexer with a registered output stage and valid/ready handshake on every channel.
- Two modes: direct select via sel_in, or round-robin arbitration across all requesting channels.
- Sits between multiple producer streams and a single consumer. Replaces hard-wired 1-bit 2:1 select logic wherever back-pressure and fairness are needed.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must equal ceil(log2(CHANNELS)), minimum 1.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous active-high reset.
- mode_in  input  1  0 = direct select, 1 = round-robin.
- sel_in  input  SEL_W  selected channel in direct mode; ignored in round-robin mode.
- data_in  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- valid_in  input  CHANNELS  per-channel valid.
- ready_out  output  CHANNELS  per-channel ready, one-hot or zero.
- data_out  output  WIDTH  registered output data.
- valid_out  output  1  registered output valid.
- ready_in  input  1  downstream ready.
- chan_out  output  SEL_W  index of the channel that supplied data_out.

Behaviour:
- Reset (asynchronous, on rst_in high):
  - data_out = 0, valid_out = 0, chan_out = 0.
  - Internal last_grant = CHANNELS-1, so channel 0 has first priority in round-robin mode.
  - ready_out is all zeros while rst_in is high.
- load_en = !valid_out || ready_in. The output register accepts a new word when it is empty or being drained this cycle.
- Grant is combinational from current inputs.
  - Direct mode: grant = sel_in when sel_in < CHANNELS and valid_in[sel_in] = 1. Otherwise no grant.
  - Round-robin mode: grant = first channel with valid_in set, searching from last_grant+1 upward and wrapping modulo CHANNELS. If no channel is valid, no grant.
- ready_out[g] = load_en for the granted channel g; all other bits are 0. ready_out never depends on valid_in of a non-granted channel.
- Transfer occurs when valid_in[g] && ready_out[g]. On the next edge:
  - data_out <= channel g data.
  - chan_out <= g.
  - valid_out <= 1.
- In round-robin mode, last_grant <= g on each transfer only. last_grant does not change in direct mode.
- load_en = 1 with no grant: valid_out <= 0. data_out and chan_out hold their previous values.
- Stall (valid_out = 1, ready_in = 0): data_out, chan_out and valid_out hold stable; ready_out is all zeros.
- Latency and throughput: 1 cycle input-to-output latency; full throughput of 1 word per cycle when ready_in is held high.
- Simultaneous drain and load: supported in the same cycle with no bubble.
- Mode or sel_in change mid-stream: takes effect on the next grant evaluation. A word already in the output register is unaffected.
- sel_in >= CHANNELS (non-power-of-two CHANNELS): no grant, all ready_out = 0. No X propagation.
- Reset mid-operation: any held word is discarded and valid_out drops immediately (asynchronously). The first grant after reset release follows the reset priority.

Test Plan:
1. Reset check: assert rst_in with valid_out = 1 mid-stall -> valid_out, data_out and chan_out go to 0 without waiting for a clock edge. After release with all four channels valid in RR mode, the first chan_out = 0.
2. Direct mode: mode_in = 0, sel_in = 2, ch2 data = 0xA5, valid_in = 4'b1111, ready_in = 1 -> ready_out = 4'b0100; next cycle data_out = 0xA5, chan_out = 2, valid_out = 1.
3. Round-robin fairness: mode_in = 1, valid_in = 4'b1111 held, ready_in = 1 for 8 cycles -> chan_out sequence 0,1,2,3,0,1,2,3 with valid_out continuously 1. With valid_in = 4'b1010, the sequence is 1,3,1,3.
4. Back-pressure: RR mode, ready_in = 0 for 3 cycles after the first word -> data_out and chan_out stable, ready_out = 0. When ready_in returns to 1, the next channel is delivered with no loss or duplication.
5. Out-of-range select: CHANNELS = 3, SEL_W = 2, sel_in = 3, valid_in = 3'b111 -> ready_out = 0 and valid_out stays 0.
6. Idle bubble: RR mode, valid_in = 0 for one cycle between words -> valid_out = 0 for exactly one cycle, and data_out holds its last value.

Source files
------------

// File: rtl/mux_nto1_stream.sv
// N-to-1 streaming mux with a registered output stage. Grant comes from either a
// direct select or round-robin arbitration; ready is returned only to the granted channel.

module mux_nto1_lane #(
  parameter int WIDTH = 8
) (
  input  logic             gnt,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             rdy,
  output logic [WIDTH-1:0] dmask
);
  assign rdy   = gnt & en;
  assign dmask = gnt ? din : '0;
endmodule

module mux_nto1_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      mode_in,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       ready_out,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [SEL_W-1:0]          chan_out
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             vld_q, vld_d;

  logic                           load_en, ld_ok, xfer;
  logic                           gnt_vld;
  logic [SEL_W-1:0]               gnt_idx;
  logic [CHANNELS-1:0]            gnt_oh;
  logic [CHANNELS-1:0][WIDTH-1:0] din_a;
  logic [CHANNELS-1:0][WIDTH-1:0] dmask;
  logic [WIDTH-1:0]               mux_data;

  assign din_a   = data_in;
  assign load_en = !vld_q || ready_in;
  // Reset must hold every ready low even though the empty output register would otherwise load.
  assign ld_ok   = load_en && !rst_in;
  assign xfer    = load_en && gnt_vld;

  // Round-robin scans offsets from largest to smallest so the nearest requester after last_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (mode_in) begin
      for (int i = CHANNELS; i >= 1; i--) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (valid_in[k] && ((int'(last_q) + i) % CHANNELS) == k) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(k);
          end
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel_in == SEL_W'(k) && valid_in[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (gnt_vld && gnt_idx == SEL_W'(k)) gnt_oh[k] = 1'b1;
  end

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      mux_nto1_lane #(.WIDTH(WIDTH)) u_lane (
        .gnt   (gnt_oh[k]),
        .en    (ld_ok),
        .din   (din_a[k]),
        .rdy   (ready_out[k]),
        .dmask (dmask[k])
      );
    end
  endgenerate

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < CHANNELS; k++) mux_data = mux_data | dmask[k];
  end

  always_comb begin
    data_d = xfer ? mux_data : data_q;
    chan_d = xfer ? gnt_idx  : chan_q;
    vld_d  = load_en ? gnt_vld : vld_q;
    last_d = (xfer && mode_in) ? gnt_idx : last_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
      last_q <= SEL_W'(CHANNELS - 1);
    end else begin
      data_q <= data_d;
      chan_q <= chan_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign data_out  = data_q;
  assign chan_out  = chan_q;
  assign valid_out = vld_q;

endmodule
